bf16_mult_arbiter: RTL and testbench

Round-robin arbiter that shares one pipelined bfloat16 multiplier among NUM_REQ requesters (the convolution lanes of the CNN datapath). It accepts operand pairs over a valid/ready handshake and drives them into the multiplier at most one per cycle. Each pair carries a requester tag through a shift register that matches the multiplier latency, so every product is routed back to the lane that issued it. The block sits between the lane controllers and the single `bfloat16_mult` instance; it has no arithmetic of its own.

---
 rtl/bf16_mult_arbiter.sv | 124 ++++++++++++
 tb/tb_bf16_mult_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_mult_arbiter.sv
// rtl/bf16_mult_arbiter.sv - round-robin arbiter sharing one pipelined bf16 multiplier among NUM_REQ lanes
// Optional build macro BF16_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority instead of round-robin.
module bf16_mult_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MULT_LAT = 2,
    parameter int IDW      = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [16*NUM_REQ-1:0]  req_a,
    input  logic [16*NUM_REQ-1:0]  req_b,
    output logic [15:0]            mul_a,
    output logic [15:0]            mul_b,
    input  logic [15:0]            mul_out,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [15:0]            resp_data,
    output logic                   busy
);

    logic               gnt_any;
    logic [IDW-1:0]     gnt_id;
    logic               xfer;
    logic [MULT_LAT-1:0] tag_v_q;
    logic [IDW-1:0]     tag_id_q [MULT_LAT];
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [15:0]        resp_data_q, resp_data_d;

`ifndef BF16_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]     ptr_q, ptr_d;
`endif

    // Search upward from the rotating pointer (or from lane 0 in the fixed-priority build).
    always_comb begin
        logic [IDW-1:0] idx;
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef BF16_ARB_FIXED_PRIO_EN
            idx = IDW'(k);
`else
            idx = IDW'((int'(ptr_q) + k) % NUM_REQ);
`endif
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    assign xfer = gnt_any & en;

    always_comb begin
        req_ready = '0;
        mul_a     = 16'h0000;
        mul_b     = 16'h0000;
        if (xfer) begin
            req_ready[gnt_id] = 1'b1;
            mul_a             = req_a[{gnt_id, 4'd0} +: 16];
            mul_b             = req_b[{gnt_id, 4'd0} +: 16];
        end
    end

`ifndef BF16_ARB_FIXED_PRIO_EN
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Tag shift register mirrors the multiplier latency so the last stage lines up with mul_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_q <= '0;
            for (int s = 0; s < MULT_LAT; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            tag_v_q[0]  <= xfer;
            tag_id_q[0] <= gnt_id;
            for (int s = 1; s < MULT_LAT; s++) begin
                tag_v_q[s]  <= tag_v_q[s-1];
                tag_id_q[s] <= tag_id_q[s-1];
            end
        end
    end

    always_comb begin
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        if (tag_v_q[MULT_LAT-1]) begin
            resp_valid_d[tag_id_q[MULT_LAT-1]] = 1'b1;
            resp_data_d                        = mul_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= '0;
            resp_data_q  <= 16'h0000;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign busy       = (|tag_v_q) | (|resp_valid_q);

endmodule

// File: tb/tb_bf16_mult_arbiter.sv
// tb/tb_bf16_mult_arbiter.sv - scoreboard bench for bf16_mult_arbiter with a 2-stage bf16 multiplier model
module tb_bf16_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  req_valid = 4'b0000;
    logic [3:0]  req_ready;
    logic [63:0] req_a, req_b;
    logic [15:0] mul_a, mul_b, mul_out;
    logic [3:0]  resp_valid;
    logic [15:0] resp_data;
    logic        busy;

    logic [15:0] la [4];
    logic [15:0] lb [4];
    logic [15:0] lexp [4];
    logic [15:0] m1, m2;

    typedef struct {
        int          lane;
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t sb [$];

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    assign req_a   = {la[3], la[2], la[1], la[0]};
    assign req_b   = {lb[3], lb[2], lb[1], lb[0]};
    assign mul_out = m2;

    bf16_mult_arbiter #(.NUM_REQ(4), .MULT_LAT(2), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
        .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic       s, g, st;
        int         e;
        logic [7:0] ma, mb, m;
        logic [15:0] p;
        logic [6:0] keep;
        s = a[15] ^ b[15];
        if (a[14:0] == 15'd0 || b[14:0] == 15'd0) return {s, 15'd0};
        ma = {1'b1, a[6:0]};
        mb = {1'b1, b[6:0]};
        p  = 16'(ma) * 16'(mb);
        e  = int'(a[14:7]) + int'(b[14:7]) - 127;
        if (p[15]) begin
            e++;
            keep = p[14:8]; g = p[7]; st = |p[6:0];
        end else begin
            keep = p[13:7]; g = p[6]; st = |p[5:0];
        end
        m = {1'b0, keep} + 8'(g && (st || keep[0]));
        if (m[7]) begin
            e++;
            m = 8'd0;
        end
        return {s, e[7:0], m[6:0]};
    endfunction

    always @(posedge clk) begin
        m1 <= bf16_mul(mul_a, mul_b);
        m2 <= m1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && resp_valid !== 4'b0000) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", {28'd0, resp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_valid", {28'd0, resp_valid}, 32'd1 << e.lane);
                chk("resp_data", {16'd0, resp_data}, {16'd0, e.data});
                chk("resp_cycle", cyc, e.due);
            end
        end
    end

    task automatic set_lane(input int i, input logic [15:0] a, input logic [15:0] b, input logic [15:0] x);
        la[i] = a; lb[i] = b; lexp[i] = x;
    endtask

    // Called at posedge+1; drives one cycle, checks at the falling edge, returns at next posedge+1.
    task automatic step(input logic [3:0] v, input logic e, input logic [3:0] exp_rdy, input int bchk);
        exp_t ent;
        int   lane;
        req_valid = v;
        en        = e;
        @(negedge clk);
        chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
        if (exp_rdy != 4'b0000) begin
            lane = 0;
            for (int i = 0; i < 4; i++) if (exp_rdy[i]) lane = i;
            chk("mul_a", {16'd0, mul_a}, {16'd0, la[lane]});
            chk("mul_b", {16'd0, mul_b}, {16'd0, lb[lane]});
            ent.lane = lane;
            ent.data = lexp[lane];
            ent.due  = cyc + 3;
            sb.push_back(ent);
        end else begin
            chk("mul_a_idle", {16'd0, mul_a}, 32'd0);
        end
        if (bchk >= 0) chk("busy", {31'd0, busy}, bchk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) set_lane(i, 16'h0000, 16'h0000, 16'h0000);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_mul_a", {16'd0, mul_a}, 32'd0);
        chk("rst_mul_b", {16'd0, mul_b}, 32'd0);
        chk("rst_resp_valid", {28'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", {16'd0, resp_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // All four lanes valid for 8 cycles: 1.5 * 2.0 = 3.0
        for (int i = 0; i < 4; i++) set_lane(i, 16'h3FC0, 16'h4000, 16'h4040);
        for (int c = 0; c < 8; c++) begin
`ifdef BF16_ARB_FIXED_PRIO_EN
            step(4'b1111, 1'b1, 4'b0001, -1);
`else
            step(4'b1111, 1'b1, 4'(1 << (c % 4)), -1);
`endif
        end

        // Wrap: pointer at 0, lanes 1 and 3 together; 1.0 * 2.0 = 2.0
        set_lane(1, 16'h3F80, 16'h4000, 16'h4000);
        set_lane(3, 16'h3F80, 16'h4000, 16'h4000);
        step(4'b1010, 1'b1, 4'b0010, -1);
`ifdef BF16_ARB_FIXED_PRIO_EN
        step(4'b1010, 1'b1, 4'b0010, -1);
`else
        step(4'b1010, 1'b1, 4'b1000, -1);
`endif
        step(4'b0000, 1'b1, 4'b0000, -1);
        step(4'b0000, 1'b1, 4'b0000, -1);
        step(4'b0000, 1'b1, 4'b0000, -1);
        step(4'b0000, 1'b1, 4'b0000, 0);

        // Single request on lane 2 with busy profile
        set_lane(2, 16'h3F80, 16'h4000, 16'h4000);
        step(4'b0100, 1'b1, 4'b0100, 0);
        step(4'b0000, 1'b1, 4'b0000, 1);
        step(4'b0000, 1'b1, 4'b0000, 1);
        step(4'b0000, 1'b1, 4'b0000, 1);
        step(4'b0000, 1'b1, 4'b0000, 0);

        // Pointer at 3, only lane 0 valid; then lanes 0,1 show the pointer moved to 1
        set_lane(0, 16'h4040, 16'h3F80, 16'h4040);
        set_lane(1, 16'h3FC0, 16'h4000, 16'h4040);
        step(4'b0001, 1'b1, 4'b0001, 0);
`ifdef BF16_ARB_FIXED_PRIO_EN
        step(4'b0011, 1'b1, 4'b0001, 1);
`else
        step(4'b0011, 1'b1, 4'b0010, 1);
`endif
        // en low with two products in flight: they drain on schedule
        step(4'b0011, 1'b0, 4'b0000, 1);
        step(4'b0011, 1'b0, 4'b0000, 1);
        step(4'b0011, 1'b0, 4'b0000, 1);
        step(4'b0011, 1'b0, 4'b0000, 0);

        // Reset one cycle after a transfer discards the product
`ifdef BF16_ARB_FIXED_PRIO_EN
        step(4'b0100, 1'b1, 4'b0100, 0);
`else
        step(4'b0100, 1'b1, 4'b0100, 0);
`endif
        req_valid = 4'b0000;
        rst_n     = 1'b0;
        @(negedge clk);
        chk("mid_rst_resp_valid", {28'd0, resp_valid}, 32'd0);
        chk("mid_rst_resp_data", {16'd0, resp_data}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("mid_rst_mul_a", {16'd0, mul_a}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        for (int c = 0; c < 4; c++) step(4'b0000, 1'b1, 4'b0000, 0);

        // Back-to-back lane 0: 3.0 * 1.0 = 3.0 every cycle
        for (int c = 0; c < 6; c++) step(4'b0001, 1'b1, 4'b0001, -1);
        step(4'b0000, 1'b1, 4'b0000, 1);
        step(4'b0000, 1'b1, 4'b0000, 1);
        step(4'b0000, 1'b1, 4'b0000, 1);
        step(4'b0000, 1'b1, 4'b0000, 0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
